seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a multi-digit common-anode seven-segment display. It is the parametrised successor of the single-digit BCD decoder. It latches NUM_DIGITS BCD values plus decimal points, scans the digits one at a time with anti-ghosting guard slots, and supports leading-zero blanking and whole-display blinking. It sits between the vending-machine controller (price, credit and change values) and the board display pins.

---
 rtl/seven_segment_scanner.sv | 179 +++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver: shadowed BCD digits,
// guard-slotted scanning, leading-zero blanking and whole-display blinking.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [7:0]              segment_data,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] GUARD_V    = SW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Active-low {dp,g,f,e,d,c,b,a}; a lit decimal point clears bit 7.
    function automatic logic [7:0] seg_code(input logic [3:0] bcd, input logic dp);
        logic [7:0] code;
        case (bcd)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'hBF;
            default: code = 8'hFF;
        endcase
        if (dp) begin
            code[7] = 1'b0;
        end else begin
            code[7] = code[7];
        end
        return code;
    endfunction

    // Bit i set when digit i and every more significant digit are zero; digit 0 never blanks.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] mask;
        logic                  run;
        mask = '0;
        run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run     = run & (d[4*i +: 4] == 4'h0);
            mask[i] = run;
        end
        return mask;
    endfunction

    logic [4*NUM_DIGITS-1:0] digits_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [SW-1:0]           slot_r;
    logic [IW-1:0]           idx_r;
    logic [FW-1:0]           frame_r;
    logic                    phase_r;

    logic [SW-1:0]           slot_nxt_s;
    logic [IW-1:0]           idx_nxt_s;
    logic [FW-1:0]           frame_nxt_s;
    logic                    phase_nxt_s;
    logic                    wrap_s;

    logic [NUM_DIGITS-1:0]   lz_s;
    logic [3:0]              cur_digit_s;
    logic                    cur_dp_s;
    logic                    dark_s;
    logic [7:0]              seg_nxt_s;
    logic [NUM_DIGITS-1:0]   sel_nxt_s;

    // Shadow capture of the displayed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r <= '0;
            dp_r     <= '0;
        end else if (load) begin
            digits_r <= digits_in;
            dp_r     <= dp_in;
        end else begin
            digits_r <= digits_r;
            dp_r     <= dp_r;
        end
    end

    // Next values of the slot, digit and blink counters.
    always_comb begin
        slot_nxt_s  = slot_r + SW'(1);
        idx_nxt_s   = idx_r;
        frame_nxt_s = frame_r;
        phase_nxt_s = phase_r;
        wrap_s      = 1'b0;
        if (slot_r == SLOT_LAST) begin
            slot_nxt_s = '0;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
                wrap_s    = 1'b1;
                if (frame_r == FRAME_LAST) begin
                    frame_nxt_s = '0;
                    phase_nxt_s = ~phase_r;
                end else begin
                    frame_nxt_s = frame_r + FW'(1);
                end
            end else begin
                idx_nxt_s = idx_r + IW'(1);
            end
        end else begin
            slot_nxt_s = slot_r + SW'(1);
        end
    end

    // Pin pattern for the state being committed this edge; shadow contents lag by one cycle.
    always_comb begin
        lz_s        = lz_mask(digits_r);
        cur_digit_s = digits_r[{idx_nxt_s, 2'b00} +: 4];
        cur_dp_s    = dp_r[idx_nxt_s];
        dark_s      = (slot_nxt_s < GUARD_V) || (blink_en && phase_nxt_s);
        seg_nxt_s   = 8'hFF;
        sel_nxt_s   = '1;
        if (dark_s) begin
            seg_nxt_s = 8'hFF;
            sel_nxt_s = '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sel_nxt_s[i] = (idx_nxt_s != IW'(i));
            end
            if (blank_lz && lz_s[idx_nxt_s]) begin
                seg_nxt_s = {~cur_dp_s, 7'h7F};
            end else begin
                seg_nxt_s = seg_code(cur_digit_s, cur_dp_s);
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r  <= '0;
            idx_r   <= '0;
            frame_r <= '0;
            phase_r <= 1'b0;
        end else begin
            slot_r  <= slot_nxt_s;
            idx_r   <= idx_nxt_s;
            frame_r <= frame_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segment_data <= 8'hFF;
            digit_sel    <= '1;
            frame_done   <= 1'b0;
        end else begin
            segment_data <= seg_nxt_s;
            digit_sel    <= sel_nxt_s;
            frame_done   <= wrap_s;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 8-cycle slots, guard 2, blink 2 frames).
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [7:0]  segment_data;
    logic [3:0]  digit_sel;
    logic        frame_done;

    seven_segment_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .blink_en(blink_en),
        .segment_data(segment_data), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fd;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle whose expectation is queued is compared on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total = total + 1;
            if (e.cyc < cyc) begin
                bad = bad + 1;
                $display("FAIL %s stale entry for cycle %0d seen at %0d", e.nm, e.cyc - base, cyc - base);
            end else if (segment_data !== e.seg || digit_sel !== e.sel || frame_done !== e.fd) begin
                bad = bad + 1;
                $display("FAIL %s k=%0d got seg=%h sel=%b fd=%b want seg=%h sel=%b fd=%b",
                         e.nm, cyc - base, segment_data, digit_sel, frame_done, e.seg, e.sel, e.fd);
            end
        end
    end

    task automatic push(input int c, input logic [7:0] seg, input logic [3:0] sel,
                        input logic fd, input string nm);
        exp_t e;
        e.cyc = c; e.seg = seg; e.sel = sel; e.fd = fd; e.nm = nm;
        q.push_back(e);
    endtask

    // Expected scan for k_from..k_to after reset release; s0..s3 are hand-computed digit codes.
    task automatic push_scan(input int k_from, input int k_to,
                             input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input int dark_from, input int dark_to, input string nm);
        logic [7:0] codes [4];
        logic [3:0] one;
        codes[0] = s0; codes[1] = s1; codes[2] = s2; codes[3] = s3;
        one = 4'b0001;
        for (int k = k_from; k <= k_to; k++) begin
            int  s;
            int  d;
            logic fd;
            s  = k % 8;
            d  = (k / 8) % 4;
            fd = (k > 0) && (k % 32 == 0);
            if (s < 2 || (k >= dark_from && k <= dark_to))
                push(base + k, 8'hFF, 4'b1111, fd, nm);
            else
                push(base + k, codes[d], ~(one << d), fd, nm);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 2000) begin
            @(posedge clk);
            t = t + 1;
        end
        if (q.size() > 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL drain %0d entries left unchecked", q.size());
            q.delete();
        end
    endtask

    // Asserts reset just after an edge, checks it for two cycles, releases with base = k0.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        load = 1'b0;
        push(cyc, 8'hFF, 4'b1111, 1'b0, nm);
        @(posedge clk);
        #1;
        push(cyc, 8'hFF, 4'b1111, 1'b0, nm);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = cyc;
    endtask

    task automatic load_at0(input logic [15:0] d, input logic [3:0] dp);
        digits_in = d;
        dp_in = dp;
        load = 1'b1;
        goto(1);
        load = 1'b0;
    endtask

    initial begin
        // Reset and plain scan of 1234, including the blink phase flip with blink disabled.
        do_reset("reset");
        push_scan(0, 64, 8'h99, 8'hB0, 8'hA4, 8'hF9, -1, -1, "scan1234");
        load_at0(16'h1234, 4'b0000);
        drain();

        // Leading-zero blanking with a decimal point, then blanking disabled.
        do_reset("reset_lz");
        blank_lz = 1'b1;
        push_scan(0, 31, 8'hC0, 8'h12, 8'hFF, 8'hFF, -1, -1, "lz_on");
        push_scan(32, 63, 8'hC0, 8'h12, 8'hC0, 8'hC0, -1, -1, "lz_off");
        load_at0(16'h0050, 4'b0010);
        goto(32);
        blank_lz = 1'b0;
        drain();

        // Minus sign and blank codes.
        do_reset("reset_codes");
        push_scan(0, 31, 8'hFF, 8'hFF, 8'hC0, 8'hBF, -1, -1, "codes");
        load_at0(16'hA0BF, 4'b0000);
        drain();

        // Blink: two frames lit, dark from k=64, enable dropped at k=100.
        do_reset("reset_blink");
        blink_en = 1'b1;
        push_scan(0, 130, 8'h99, 8'hB0, 8'hA4, 8'hF9, 64, 100, "blink");
        load_at0(16'h1234, 4'b0000);
        goto(100);
        blink_en = 1'b0;
        drain();

        // Load inside digit 0's active slot, then async reset mid-slot of digit 2.
        do_reset("reset_mid");
        push_scan(0, 4, 8'h99, 8'hB0, 8'hA4, 8'hF9, -1, -1, "midload_old");
        push_scan(5, 19, 8'h80, 8'hB0, 8'hA4, 8'hF9, -1, -1, "midload_new");
        load_at0(16'h1234, 4'b0000);
        goto(3);
        digits_in = 16'h1238;
        load = 1'b1;
        goto(4);
        load = 1'b0;
        goto(19);
        do_reset("reset_async");
        push_scan(0, 31, 8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, -1, "shadow_cleared");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
